// File: rtl/xbar_pack_buf.sv
// Two-lane packing buffer: gap-free packs 0/1/2 crossbar words per cycle into a
// circular buffer and emits OUT_WORDS-wide beats, with a flush marker for partial beats.

module xbar_pack_buf_slot #(
  parameter int DW  = 35,
  parameter int OCW = 3,
  parameter int K   = 0
) (
  input  logic [DW-1:0]  word,
  input  logic [OCW-1:0] cnt,
  output logic [DW-1:0]  out
);
  localparam logic [OCW-1:0] KV = OCW'(K);
  // Slots past the meaningful word count read as zero
  assign out = (cnt > KV) ? word : '0;
endmodule

module xbar_pack_buf #(
  parameter int DW        = 35,
  parameter int OUT_WORDS = 4,
  parameter int DEPTH     = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DW-1:0]                     i_data0,
  input  logic                              i_valid0,
  input  logic [DW-1:0]                     i_data1,
  input  logic                              i_valid1,
  input  logic                              i_last,
  output logic                              o_ready,
  output logic [OUT_WORDS*DW-1:0]           o_data,
  output logic                              o_valid,
  output logic [$clog2(OUT_WORDS+1)-1:0]    o_cnt,
  output logic                              o_last,
  input  logic                              i_ready
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int OCW = $clog2(OUT_WORDS+1);
  localparam logic [CW-1:0] HI_WM = CW'(DEPTH-2);
  localparam logic [CW-1:0] BEAT  = CW'(OUT_WORDS);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count;
  logic                     last_pend;
  logic                     accept, pop, flush;
  logic [1:0]               n_push;
  logic [OCW-1:0]           cnt_beat;

  // Ready looks only at registered state so upstream sees no input-to-ready path
  assign o_ready  = !last_pend && (count <= HI_WM);
  assign accept   = o_ready && (i_valid0 || i_valid1 || i_last);
  assign n_push   = accept ? (2'(i_valid0) + 2'(i_valid1)) : 2'd0;
  assign flush    = last_pend && (count <= BEAT);
  assign o_valid  = (count >= BEAT) || last_pend;
  assign o_last   = flush;
  assign cnt_beat = flush ? count[OCW-1:0] : OCW'(OUT_WORDS);
  assign o_cnt    = o_valid ? cnt_beat : '0;
  assign pop      = o_valid && i_ready;

  // Lane 1 lands right behind lane 0, or at wr_ptr when lane 0 is idle
  always_ff @(posedge clk) begin
    if (accept && i_valid0) mem[wr_ptr] <= i_data0;
    if (accept && i_valid1) mem[wr_ptr + AW'(i_valid0)] <= i_data1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_pend <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + (pop ? AW'(o_cnt) : '0);
      count  <= count + CW'(n_push) - (pop ? CW'(o_cnt) : '0);
      if (accept && i_last)       last_pend <= 1'b1;
      else if (pop && o_last)     last_pend <= 1'b0;
    end
  end

  for (genvar k = 0; k < OUT_WORDS; k++) begin : g_slot
    logic [AW-1:0] idx;
    assign idx = rd_ptr + AW'(k);
    xbar_pack_buf_slot #(.DW(DW), .OCW(OCW), .K(k)) u_slot (
      .word (mem[idx]),
      .cnt  (o_cnt),
      .out  (o_data[k*DW +: DW])
    );
  end
endmodule
